option_param_loader: RTL and testbench
======================================

OPTION_PARAM_LOADER -- requirements
Module: option_param_loader

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 6, giving the number of 16-bit option parameters loaded per job.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port state  input  2  host mode: 00 IDLE, 01 LOAD, 10 RUN, 11 READ.
REQ-005 SHALL have port in  input  12  load beat: [11:9] field index, [8] byte select (1 = high byte), [7:0] data byte.
REQ-006 SHALL have ports s0, k, r, sigma, t  output  16 each  active fp16 parameters (fields 0..4).
REQ-007 SHALL have port num_paths  output  16  active path count (field 5, unsigned).
REQ-008 SHALL have port start  output  1  one-cycle pulse on job launch, to Sobol and path generator.
REQ-009 SHALL have ports path_valid  output  1  and  path_ready  input  1  per-path request handshake to the path generator.
REQ-010 SHALL have port path_idx  output  16  index of the currently offered path.
REQ-011 SHALL have ports busy, done, cfg_err  output  1 each  status flags.

Function
REQ-012 SHALL implement FSM states S_IDLE, S_LOAD, S_RUN, S_DONE, evaluated every cycle from the host state input.
REQ-013 In S_IDLE, state==01 SHALL move to S_LOAD and clear the 12-bit byte-written mask and cfg_err.
REQ-014 In S_LOAD, every cycle with state==01 SHALL write in[7:0] into the selected shadow byte and set its mask bit; rewrites overwrite.
REQ-015 Field index 6 or 7 SHALL write nothing and SHALL set cfg_err (sticky until next S_LOAD entry).
REQ-016 In S_LOAD, state==10 with all 12 mask bits set SHALL copy all shadows to active outputs, assert start for exactly one cycle, and enter S_RUN.
REQ-017 In S_LOAD, state==10 with mask incomplete SHALL set cfg_err, leave active outputs unchanged, and return to S_IDLE.
REQ-018 In S_LOAD, state==00 SHALL return to S_IDLE keeping the mask; state==11 SHALL hold S_LOAD without writing.
REQ-019 In S_RUN, path_valid SHALL be high while remaining count > 0; path_idx starts at 0 and increments by 1 on each cycle path_valid && path_ready.
REQ-020 path_valid SHALL not drop and path_idx SHALL not change while path_valid && !path_ready.
REQ-021 On the handshake of path num_paths-1, S_RUN SHALL move to S_DONE next cycle with path_valid low.
REQ-022 num_paths==0 SHALL enter S_RUN, never assert path_valid, and reach S_DONE one cycle after start.
REQ-023 In S_RUN, state==00 SHALL abort: path_valid low next cycle, go to S_IDLE, done stays 0.
REQ-024 busy SHALL equal (FSM==S_RUN); done SHALL equal (FSM==S_DONE).
REQ-025 In S_DONE, state==00 SHALL go to S_IDLE, state==01 to S_LOAD (mask cleared); 10/11 hold.
REQ-026 Active outputs SHALL change only on S_RUN entry, stable throughout a run regardless of further beats.

Reset
REQ-027 rst SHALL force S_IDLE; clear mask, shadows, active parameters, num_paths, path_idx; deassert start, path_valid, busy, done, cfg_err; rst has priority over all inputs, including mid-run.

Verification
REQ-028 Load S0=0x5640 (beats 0x156, 0x040), fields 1..4 = 0x5A40, 0x2666, 0x3266, 0x3C00, num_paths=3 (0xB00, 0xA03), then state=10 -> start pulse 1 cycle, s0==0x5640, busy==1.
REQ-029 Same job, path_ready=1 always -> path_idx 0,1,2 on consecutive cycles, done==1 the cycle after idx 2 handshake.
REQ-030 path_ready toggling 1,0,0,1 with num_paths=2 -> path_idx holds during stalls, exactly 2 handshakes counted.
REQ-031 Load omitting field 3 low byte, state=10 -> cfg_err==1, no start, FSM S_IDLE; beat 0xE12 in LOAD -> cfg_err==1.
REQ-032 num_paths=0 -> start, no path_valid, done next cycle; state=00 mid-run with num_paths=100 -> path_valid low next cycle, done==0.
REQ-033 rst asserted in S_RUN at path_idx=5 -> all outputs zero next cycle, FSM S_IDLE.

Source files
------------

// File: rtl/option_param_loader.sv
// Option parameter loader: the host streams byte beats into shadow registers.
// A complete load is copied into the active parameter set on job launch. The
// loader then offers one path request per index to the path generator until
// the job's path count is exhausted.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for the host to enter LOAD mode
//   S_LOAD  | accepting byte beats into the shadow registers
//   S_RUN   | active parameters frozen, offering path requests
//   S_DONE  | all paths handed off, waiting for the host to leave RUN
module option_param_loader #(
  parameter int NUM_FIELDS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic [11:0] in,
  output logic [15:0] s0,
  output logic [15:0] k,
  output logic [15:0] r,
  output logic [15:0] sigma,
  output logic [15:0] t,
  output logic [15:0] num_paths,
  output logic        start,
  output logic        path_valid,
  input  logic        path_ready,
  output logic [15:0] path_idx,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  localparam int MASK_W = 2 * NUM_FIELDS;

  localparam logic [1:0] HOST_IDLE = 2'b00;
  localparam logic [1:0] HOST_LOAD = 2'b01;
  localparam logic [1:0] HOST_RUN  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic [MASK_W-1:0]            mask_q;
  logic [NUM_FIELDS-1:0][15:0]  shadow_q;
  logic [NUM_FIELDS-1:0][15:0]  active_q;
  logic [15:0]                  remain_q;
  logic [15:0]                  idx_q;
  logic                         start_q;
  logic                         err_q;

  logic [2:0] beat_fld;
  logic       beat_hi;
  logic [7:0] beat_byte;
  logic       beat_ok;
  logic       mask_full;
  logic       handshake;

  logic clr_mask;
  logic wr_beat;
  logic launch;
  logic set_err;
  logic advance;

  assign beat_fld  = in[11:9];
  assign beat_hi   = in[8];
  assign beat_byte = in[7:0];
  assign beat_ok   = int'(beat_fld) < NUM_FIELDS;
  assign mask_full = &mask_q;

  assign path_valid = (fsm_q == S_RUN) && (remain_q != 16'd0);
  assign handshake  = path_valid && path_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state decode and datapath strobes
  always_comb begin
    fsm_d    = fsm_q;
    clr_mask = 1'b0;
    wr_beat  = 1'b0;
    launch   = 1'b0;
    set_err  = 1'b0;
    advance  = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (state == HOST_LOAD) begin
          fsm_d    = S_LOAD;
          clr_mask = 1'b1;
        end
      end
      S_LOAD: begin
        case (state)
          HOST_LOAD: begin
            wr_beat = 1'b1;
            if (!beat_ok) set_err = 1'b1;
          end
          HOST_RUN: begin
            if (mask_full) begin
              launch = 1'b1;
              fsm_d  = S_RUN;
            end else begin
              set_err = 1'b1;
              fsm_d   = S_IDLE;
            end
          end
          HOST_IDLE: fsm_d = S_IDLE;
          default:   fsm_d = S_LOAD;
        endcase
      end
      S_RUN: begin
        // Abort wins over a same-cycle handshake; the run is discarded.
        if (state == HOST_IDLE) begin
          fsm_d = S_IDLE;
        end else if (remain_q == 16'd0) begin
          fsm_d = S_DONE;
        end else if (handshake) begin
          advance = 1'b1;
          if (remain_q == 16'd1) fsm_d = S_DONE;
        end
      end
      S_DONE: begin
        if (state == HOST_IDLE) begin
          fsm_d = S_IDLE;
        end else if (state == HOST_LOAD) begin
          fsm_d    = S_LOAD;
          clr_mask = 1'b1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Shadow/active registers, byte mask, path counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q   <= '0;
      shadow_q <= '0;
      active_q <= '0;
      remain_q <= '0;
      idx_q    <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= launch;
      if (clr_mask) begin
        mask_q <= '0;
        err_q  <= 1'b0;
      end
      if (set_err) err_q <= 1'b1;
      if (wr_beat && beat_ok) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          if (beat_fld == 3'(i)) begin
            if (beat_hi) begin
              shadow_q[i][15:8] <= beat_byte;
              mask_q[2*i+1]     <= 1'b1;
            end else begin
              shadow_q[i][7:0]  <= beat_byte;
              mask_q[2*i]       <= 1'b1;
            end
          end
        end
      end
      if (launch) begin
        active_q <= shadow_q;
        remain_q <= shadow_q[5];
        idx_q    <= '0;
      end else if (advance) begin
        remain_q <= remain_q - 16'd1;
        idx_q    <= idx_q + 16'd1;
      end
    end
  end

  assign s0        = active_q[0];
  assign k         = active_q[1];
  assign r         = active_q[2];
  assign sigma     = active_q[3];
  assign t         = active_q[4];
  assign num_paths = active_q[5];
  assign start     = start_q;
  assign path_idx  = idx_q;
  assign cfg_err   = err_q;
  assign busy      = (fsm_q == S_RUN);
  assign done      = (fsm_q == S_DONE);

endmodule

// File: tb/tb_option_param_loader.sv
// Bench for option_param_loader: directed job scenarios plus randomized jobs,
// with a scoreboard monitor checking launched parameters and path indices.
module tb_option_param_loader;

  typedef logic [5:0][15:0] pset_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic [11:0] in_beat;
  logic [15:0] s0, k, r, sigma, t, num_paths, path_idx;
  logic        start, path_valid, path_ready, busy, done, cfg_err;

  int tot_cnt  = 0;
  int pass_cnt = 0;
  int hs_cnt   = 0;

  pset_t       launch_q[$];
  int          idx_q[$];
  pset_t       m_sh;
  logic [11:0] m_mask;
  logic        m_err;
  pset_t       m_last;

  option_param_loader #(.NUM_FIELDS(6)) dut (
    .clk(clk), .rst(rst), .state(state), .in(in_beat),
    .s0(s0), .k(k), .r(r), .sigma(sigma), .t(t), .num_paths(num_paths),
    .start(start), .path_valid(path_valid), .path_ready(path_ready),
    .path_idx(path_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pset_t dut_params();
    return {num_paths, t, sigma, r, k, s0};
  endfunction

  // Scoreboard monitor: launches and path handshakes seen between edges
  always @(negedge clk) begin
    if (!rst) begin
      if (start) begin
        if (launch_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          pset_t e;
          pset_t a;
          e = launch_q.pop_front();
          a = dut_params();
          for (int i = 0; i < 6; i++) check($sformatf("launch_param%0d", i), a[i], e[i]);
        end
      end
      if (path_valid && path_ready) begin
        hs_cnt++;
        if (idx_q.size() == 0) check("unexpected_handshake", 1, 0);
        else check("path_idx_hs", path_idx, idx_q.pop_front());
      end
    end
  end

  task automatic enter_load();
    state = 2'b01; in_beat = 12'h000;
    tick();
    m_mask = '0; m_err = 1'b0;
  endtask

  task automatic beat(input int fld, input int hi, input logic [7:0] d);
    state = 2'b01; in_beat = {fld[2:0], hi[0], d};
    tick();
    if (fld < 6) begin
      m_sh[fld][hi*8 +: 8] = d;
      m_mask[fld*2 + hi]   = 1'b1;
    end else m_err = 1'b1;
  endtask

  task automatic hold_beat();
    state = 2'b11; in_beat = 12'($urandom);
    tick();
  endtask

  // Load every byte of p except slot 'skip' (fld*2+hi), optionally scrambled
  task automatic load_all(input pset_t p, input int skip, input bit rnd);
    int ord[12];
    for (int i = 0; i < 12; i++) ord[i] = rnd ? i : (i ^ 1);
    if (rnd) begin
      for (int i = 11; i > 0; i--) begin
        int j, tmp;
        j = $urandom_range(0, i);
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
    end
    for (int i = 0; i < 12; i++) begin
      int f, h;
      f = ord[i] / 2; h = ord[i] % 2;
      if (ord[i] != skip) begin
        if (rnd && ($urandom_range(0, 3) == 0)) beat(f, h, 8'($urandom));
        if (rnd && ($urandom_range(0, 3) == 0)) hold_beat();
        beat(f, h, p[f][h*8 +: 8]);
      end
    end
  endtask

  task automatic launch_go();
    state = 2'b10; in_beat = 12'h000;
    if (&m_mask) begin
      launch_q.push_back(m_sh);
      m_last = m_sh;
      for (int i = 0; i < int'(m_sh[5]); i++) idx_q.push_back(i);
    end else m_err = 1'b1;
    tick();
  endtask

  task automatic run_to_done(input int np, input bit rnd);
    int h0, n;
    h0 = hs_cnt; n = 0;
    while (!done && n < np * 20 + 20) begin
      path_ready = rnd ? 1'($urandom) : 1'b1;
      if (rnd) begin
        state   = ($urandom_range(0, 2) == 0) ? 2'b01 : (1'($urandom) ? 2'b11 : 2'b10);
        in_beat = 12'($urandom);
      end
      tick();
      n++;
    end
    check("run_done", done, 1);
    check("handshake_count", hs_cnt - h0, np);
    check("params_stable", (dut_params() == m_last), 1);
    check("valid_low_at_done", path_valid, 0);
  endtask

  function automatic pset_t mkp(input int np);
    pset_t p;
    for (int i = 0; i < 5; i++) p[i] = 16'($urandom);
    p[5] = 16'(np);
    return p;
  endfunction

  initial begin
    pset_t p;
    int    h0;
    rst = 1'b1; state = 2'b00; in_beat = 12'h000; path_ready = 1'b0;
    m_sh = '0; m_mask = '0; m_err = 1'b0; m_last = '0;
    repeat (3) tick();
    check("rst_params", (dut_params() == '0), 1);
    check("rst_start", start, 0);
    check("rst_valid", path_valid, 0);
    check("rst_idx", path_idx, 0);
    check("rst_flags", {busy, done, cfg_err}, 0);
    rst = 1'b0;

    // Reference job: three paths with path_ready held high
    p = {16'd3, 16'h3C00, 16'h3266, 16'h2666, 16'h5A40, 16'h5640};
    path_ready = 1'b1;
    enter_load();
    load_all(p, -1, 1'b0);
    launch_go();
    check("job1_start", start, 1);
    check("job1_s0", s0, 16'h5640);
    check("job1_busy", busy, 1);
    check("job1_idx0", {path_valid, path_idx}, {1'b1, 16'd0});
    tick();
    check("job1_start_pulse", start, 0);
    check("job1_idx1", path_idx, 1);
    tick();
    check("job1_idx2", path_idx, 2);
    tick();
    check("job1_done", {done, busy, path_valid}, 3'b100);

    // Two-path job with ready pattern 1,0,0,1
    p[5] = 16'd2;
    path_ready = 1'b0;
    enter_load();
    load_all(p, -1, 1'b0);
    launch_go();
    h0 = hs_cnt;
    check("stall_idx_c0", {path_valid, path_idx}, {1'b1, 16'd0});
    path_ready = 1'b1; tick();
    check("stall_idx_c1", {path_valid, path_idx}, {1'b1, 16'd1});
    path_ready = 1'b0; tick();
    check("stall_idx_c2", {path_valid, path_idx}, {1'b1, 16'd1});
    path_ready = 1'b0; tick();
    check("stall_idx_c3", {path_valid, path_idx}, {1'b1, 16'd1});
    path_ready = 1'b1; tick();
    check("stall_done", {done, path_valid}, 2'b10);
    check("stall_handshakes", hs_cnt - h0, 2);

    // Incomplete load: field 3 low byte missing
    state = 2'b00; tick();
    enter_load();
    load_all(mkp(4), 6, 1'b0);
    launch_go();
    check("incomplete_err", cfg_err, m_err);
    check("incomplete_no_start", {start, busy, done}, 0);
    check("incomplete_params_kept", (dut_params() == m_last), 1);
    enter_load();
    check("err_cleared_on_load", cfg_err, 0);
    beat(7, 0, 8'h12);
    check("bad_field_err", cfg_err, 1);
    state = 2'b00; tick();

    // Zero-path job
    enter_load();
    load_all(mkp(0), -1, 1'b1);
    launch_go();
    check("np0_start", {start, busy, path_valid}, 3'b110);
    tick();
    check("np0_done", {done, busy, path_valid}, 3'b100);

    // Abort mid-run
    path_ready = 1'b1;
    enter_load();
    load_all(mkp(100), -1, 1'b1);
    launch_go();
    repeat (3) tick();
    state = 2'b00; tick();
    check("abort_state", {path_valid, done, busy}, 0);
    idx_q.delete();

    // Reset mid-run at path_idx 5
    enter_load();
    load_all(mkp(20), -1, 1'b1);
    launch_go();
    repeat (5) tick();
    check("pre_rst_idx", path_idx, 5);
    rst = 1'b1; tick();
    check("midrun_rst_params", (dut_params() == '0), 1);
    check("midrun_rst_outs", {start, path_valid, busy, done, cfg_err, path_idx}, 0);
    rst = 1'b0;
    idx_q.delete(); launch_q.delete();
    m_sh = '0; m_mask = '0; m_err = 1'b0; m_last = '0;

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      int np;
      np = $urandom_range(0, 10);
      enter_load();
      load_all(mkp(np), -1, 1'b1);
      check("rnd_load_err", cfg_err, m_err);
      launch_go();
      check("rnd_start", start, 1);
      run_to_done(np, 1'b1);
    end

    check("launch_queue_empty", launch_q.size(), 0);
    check("idx_queue_empty", idx_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
